rvh_ptw_mem_responder: RTL and testbench

RVH_PTW_MEM_RESPONDER -- requirements
Module: rvh_ptw_mem_responder

---
 rtl/rvh_ptw_mem_responder.sv | 117 +++++++++++
 tb/tb_rvh_ptw_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_ptw_mem_responder.sv
// PTE fetch responder for the page-table walker: turns one walk request at a time
// into a single 64-bit memory read and returns the PTE, or an error for a misaligned PTE.
module rvh_ptw_mem_responder #(
   parameter int unsigned PADDR_WIDTH  = 56,
   parameter int unsigned PTW_ID_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   // walk request from the MMU
   input  logic                    ptw_walk_req_vld_i,
   input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
   input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
   output logic                    ptw_walk_req_rdy_o,
   // walk response to the MMU
   output logic                    ptw_walk_resp_vld_o,
   output logic [63:0]             ptw_walk_resp_pte_o,
   output logic [PTW_ID_WIDTH-1:0] ptw_walk_resp_id_o,
   output logic                    ptw_walk_resp_err_o,
   input  logic                    ptw_walk_resp_rdy_i,
   // memory read request
   output logic                    mem_req_vld_o,
   output logic [PADDR_WIDTH-1:0]  mem_req_addr_o,
   input  logic                    mem_req_rdy_i,
   // memory read response
   input  logic                    mem_resp_vld_i,
   input  logic [63:0]             mem_resp_data_i,
   input  logic                    mem_resp_err_i,
   output logic                    mem_resp_rdy_o
);

   typedef enum logic [1:0] {
      StIdle,
      StMemReq,
      StMemWait,
      StResp
   } state_e;

   state_e                  state_q, state_d;
   logic [PADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [PTW_ID_WIDTH-1:0] id_q, id_d;
   logic [63:0]             pte_q, pte_d;
   logic                    err_q, err_d;
   logic                    req_aligned;

   // A PTE is 8 bytes; anything not 8-byte aligned is answered locally with an error.
   assign req_aligned = (ptw_walk_req_addr_i[2:0] == 3'b000);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         addr_q  <= '0;
         id_q    <= '0;
         pte_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         pte_q   <= pte_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      pte_d   = pte_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (ptw_walk_req_vld_i) begin
               addr_d = ptw_walk_req_addr_i;
               id_d   = ptw_walk_req_id_i;
               pte_d  = '0;
               if (req_aligned) begin
                  err_d   = 1'b0;
                  state_d = StMemReq;
               end else begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StMemReq: begin
            if (mem_req_rdy_i) begin
               state_d = StMemWait;
            end
         end
         StMemWait: begin
            if (mem_resp_vld_i) begin
               pte_d   = mem_resp_err_i ? 64'd0 : mem_resp_data_i;
               err_d   = mem_resp_err_i;
               state_d = StResp;
            end
         end
         StResp: begin
            if (ptw_walk_resp_rdy_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Every output decodes the state register or is a register itself, so the memory
   // request and the walk response stay stable for as long as their handshake stalls.
   assign ptw_walk_req_rdy_o  = (state_q == StIdle);
   assign mem_req_vld_o       = (state_q == StMemReq);
   assign mem_req_addr_o      = addr_q;
   assign mem_resp_rdy_o      = (state_q == StMemWait);
   assign ptw_walk_resp_vld_o = (state_q == StResp);
   assign ptw_walk_resp_pte_o = pte_q;
   assign ptw_walk_resp_id_o  = id_q;
   assign ptw_walk_resp_err_o = err_q;

endmodule

// File: tb/tb_rvh_ptw_mem_responder.sv
// Bench for rvh_ptw_mem_responder: directed vector table, multi-cycle corner sequences
// and a randomized run scored against a transaction-level model.
`timescale 1ns / 1ps
module tb_rvh_ptw_mem_responder;

   localparam int unsigned AW = 56;

   logic          clk;
   logic          rstn;
   logic          req_vld;
   logic          req_id;
   logic [AW-1:0] req_addr;
   logic          req_rdy;
   logic          resp_vld;
   logic [63:0]   resp_pte;
   logic          resp_id;
   logic          resp_err;
   logic          resp_rdy;
   logic          mem_req_vld;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_rdy;
   logic          mem_resp_vld;
   logic [63:0]   mem_resp_data;
   logic          mem_resp_err;
   logic          mem_resp_rdy;

   int checks = 0;
   int errors = 0;

   rvh_ptw_mem_responder #(
      .PADDR_WIDTH (AW),
      .PTW_ID_WIDTH(1)
   ) dut (
      .clk                (clk),
      .rstn               (rstn),
      .ptw_walk_req_vld_i (req_vld),
      .ptw_walk_req_id_i  (req_id),
      .ptw_walk_req_addr_i(req_addr),
      .ptw_walk_req_rdy_o (req_rdy),
      .ptw_walk_resp_vld_o(resp_vld),
      .ptw_walk_resp_pte_o(resp_pte),
      .ptw_walk_resp_id_o (resp_id),
      .ptw_walk_resp_err_o(resp_err),
      .ptw_walk_resp_rdy_i(resp_rdy),
      .mem_req_vld_o      (mem_req_vld),
      .mem_req_addr_o     (mem_req_addr),
      .mem_req_rdy_i      (mem_req_rdy),
      .mem_resp_vld_i     (mem_resp_vld),
      .mem_resp_data_i    (mem_resp_data),
      .mem_resp_err_i     (mem_resp_err),
      .mem_resp_rdy_o     (mem_resp_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          id;
      logic [63:0]   data;
      logic          merr;
      logic [63:0]   exp_pte;
      logic          exp_err;
      int            exp_lat;
      logic          exp_mem;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
      check({tag, "_resp_vld"}, 64'(resp_vld), 64'd0);
      check({tag, "_pte"}, resp_pte, 64'd0);
      check({tag, "_id"}, 64'(resp_id), 64'd0);
      check({tag, "_err"}, 64'(resp_err), 64'd0);
      check({tag, "_mem_req_vld"}, 64'(mem_req_vld), 64'd0);
      check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 64'd0);
      check({tag, "_mem_resp_rdy"}, 64'(mem_resp_rdy), 64'd0);
   endtask

   // Zero-wait memory and an always-ready MMU; latency counted from the accept cycle.
   task automatic run_vec(input vec_t v);
      int cyc;
      req_vld       = 1'b1;
      req_id        = v.id;
      req_addr      = v.addr;
      resp_rdy      = 1'b1;
      mem_req_rdy   = 1'b1;
      mem_resp_data = v.data;
      mem_resp_err  = v.merr;
      check("vec_req_rdy", 64'(req_rdy), 64'd1);
      tick();
      req_vld = 1'b0;
      cyc     = 1;
      check("vec_mem_req_vld", 64'(mem_req_vld), 64'(v.exp_mem));
      if (v.exp_mem) check("vec_mem_req_addr", 64'(mem_req_addr), 64'(v.addr));
      while (!resp_vld && cyc < 20) begin
         mem_resp_vld = mem_resp_rdy;
         tick();
         cyc++;
      end
      mem_resp_vld = 1'b0;
      check("vec_latency", 64'(cyc), 64'(v.exp_lat));
      check("vec_pte", resp_pte, v.exp_pte);
      check("vec_id", 64'(resp_id), 64'(v.id));
      check("vec_err", 64'(resp_err), 64'(v.exp_err));
      tick();
      check("vec_rdy_after", 64'(req_rdy), 64'd1);
      check("vec_resp_done", 64'(resp_vld), 64'd0);
   endtask

   // Randomized run: the model tracks one transaction as a few phase flags and predicts
   // the response from the request and the memory's answer.
   task automatic run_random(input int n_txn);
      logic          busy, al, iss, ret;
      logic [AW-1:0] t_addr;
      logic          t_id, t_merr, exp_err;
      logic [63:0]   t_data, exp_pte;
      logic [3:0]    exp_flags;
      int            ntx, cyc;
      busy = 1'b0; al = 1'b0; iss = 1'b0; ret = 1'b0;
      t_addr = '0; t_id = 1'b0; t_merr = 1'b0; t_data = '0;
      exp_pte = '0; exp_err = 1'b0;
      ntx = 0;
      cyc = 0;
      while (ntx < n_txn && cyc < 20000) begin
         exp_flags = {!busy, busy && al && !iss, busy && al && iss && !ret,
                      busy && (!al || ret)};
         check("rnd_flags", 64'({req_rdy, mem_req_vld, mem_resp_rdy, resp_vld}),
               64'(exp_flags));
         if (mem_req_vld) check("rnd_mem_addr", 64'(mem_req_addr), 64'(t_addr));

         req_vld  = 1'($urandom_range(0, 1));
         req_id   = 1'($urandom_range(0, 1));
         req_addr = AW'({$urandom, $urandom});
         if ($urandom_range(0, 3) != 0) req_addr[2:0] = 3'b000;
         resp_rdy    = ($urandom_range(0, 2) != 0);
         mem_req_rdy = 1'($urandom_range(0, 1));
         if (busy && al && iss && !ret) begin
            mem_resp_vld  = 1'($urandom_range(0, 1));
            mem_resp_data = t_data;
            mem_resp_err  = t_merr;
         end else begin
            mem_resp_vld  = ($urandom_range(0, 7) == 0);
            mem_resp_data = {$urandom, $urandom};
            mem_resp_err  = 1'($urandom_range(0, 1));
         end

         if (resp_vld && resp_rdy) begin
            check("rnd_pte", resp_pte, exp_pte);
            check("rnd_id", 64'(resp_id), 64'(t_id));
            check("rnd_err", 64'(resp_err), 64'(exp_err));
            busy = 1'b0;
            ntx++;
         end
         if (mem_resp_rdy && mem_resp_vld) ret = 1'b1;
         if (mem_req_vld && mem_req_rdy) iss = 1'b1;
         if (req_rdy && req_vld) begin
            busy   = 1'b1;
            t_addr = req_addr;
            t_id   = req_id;
            al     = (req_addr % 8 == 0);
            iss    = 1'b0;
            ret    = 1'b0;
            t_data = {$urandom, $urandom};
            t_merr = ($urandom_range(0, 3) == 0);
            exp_err = !al || t_merr;
            exp_pte = exp_err ? 64'd0 : t_data;
         end
         tick();
         cyc++;
      end
      check("rnd_txn_count", 64'(ntx), 64'(n_txn));
      req_vld = 1'b0; mem_resp_vld = 1'b0; resp_rdy = 1'b1;
   endtask

   initial begin
      vecs[0] = '{56'h80001008, 1'b1, 64'h200000CF, 1'b0, 64'h200000CF, 1'b0, 3, 1'b1};
      vecs[1] = '{56'h80001004, 1'b0, 64'h55, 1'b0, 64'h0, 1'b1, 1, 1'b0};
      vecs[2] = '{56'h80002000, 1'b1, 64'hFFFF, 1'b1, 64'h0, 1'b1, 3, 1'b1};
      vecs[3] = '{56'hFFFFFFFFFFFFF8, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0,
                  64'hDEADBEEFCAFEF00D, 1'b0, 3, 1'b1};
      vecs[4] = '{56'h1, 1'b1, 64'h1, 1'b0, 64'h0, 1'b1, 1, 1'b0};
      vecs[5] = '{56'h80001002, 1'b0, 64'h2, 1'b1, 64'h0, 1'b1, 1, 1'b0};

      rstn = 1'b0;
      req_vld = 1'b0; req_id = 1'b0; req_addr = '0; resp_rdy = 1'b0;
      mem_req_rdy = 1'b0; mem_resp_vld = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
      #12;
      check_reset_outputs("reset");
      #5 rstn = 1'b1;
      tick();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Memory stalls the read for 5 cycles, then the MMU stalls the response for 3.
      req_vld = 1'b1; req_id = 1'b1; req_addr = 56'h80003010;
      mem_req_rdy = 1'b0; resp_rdy = 1'b0;
      mem_resp_data = 64'h123456789ABCDEF0; mem_resp_err = 1'b0;
      tick();
      req_vld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_mem_vld", 64'(mem_req_vld), 64'd1);
         check("stall_mem_addr", 64'(mem_req_addr), 64'h80003010);
         check("stall_req_rdy", 64'(req_rdy), 64'd0);
         tick();
      end
      mem_req_rdy = 1'b1;
      tick();
      mem_req_rdy = 1'b0;
      check("stall_wait_rdy", 64'(mem_resp_rdy), 64'd1);
      check("stall_mem_vld_off", 64'(mem_req_vld), 64'd0);
      mem_resp_vld = 1'b1;
      tick();
      mem_resp_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_resp_vld", 64'(resp_vld), 64'd1);
         check("stall_resp_pte", resp_pte, 64'h123456789ABCDEF0);
         check("stall_resp_id", 64'(resp_id), 64'd1);
         check("stall_resp_req_rdy", 64'(req_rdy), 64'd0);
         tick();
      end
      resp_rdy = 1'b1;
      check("stall_resp_still", 64'(resp_vld), 64'd1);
      tick();
      check("stall_done_rdy", 64'(req_rdy), 64'd1);
      check("stall_done_vld", 64'(resp_vld), 64'd0);

      // Second request held while busy and a spurious read response in MEM_REQ.
      req_vld = 1'b1; req_id = 1'b0; req_addr = 56'h80004000;
      mem_req_rdy = 1'b0; resp_rdy = 1'b1;
      tick();
      req_id = 1'b1; req_addr = 56'h80005008;
      mem_resp_vld = 1'b1; mem_resp_data = 64'hBAD0BAD0; mem_resp_err = 1'b0;
      check("busy_mem_resp_rdy", 64'(mem_resp_rdy), 64'd0);
      check("busy_req_rdy", 64'(req_rdy), 64'd0);
      tick();
      mem_resp_vld = 1'b0;
      check("spur_mem_vld", 64'(mem_req_vld), 64'd1);
      check("spur_mem_addr", 64'(mem_req_addr), 64'h80004000);
      check("spur_resp_vld", 64'(resp_vld), 64'd0);
      mem_req_rdy = 1'b1;
      tick();
      mem_req_rdy = 1'b0;
      check("busy_wait_rdy", 64'(mem_resp_rdy), 64'd1);
      check("busy_wait_req_rdy", 64'(req_rdy), 64'd0);
      mem_resp_vld = 1'b1; mem_resp_data = 64'h1111;
      tick();
      mem_resp_vld = 1'b0;
      check("first_resp_vld", 64'(resp_vld), 64'd1);
      check("first_resp_pte", resp_pte, 64'h1111);
      check("first_resp_id", 64'(resp_id), 64'd0);
      check("first_req_rdy", 64'(req_rdy), 64'd0);
      tick();
      check("second_req_rdy", 64'(req_rdy), 64'd1);
      tick();
      req_vld = 1'b0;
      check("second_mem_vld", 64'(mem_req_vld), 64'd1);
      check("second_mem_addr", 64'(mem_req_addr), 64'h80005008);
      mem_req_rdy = 1'b1;
      tick();
      mem_req_rdy = 1'b0;
      mem_resp_vld = 1'b1; mem_resp_data = 64'h2222;
      tick();
      mem_resp_vld = 1'b0;
      check("second_resp_pte", resp_pte, 64'h2222);
      check("second_resp_id", 64'(resp_id), 64'd1);
      tick();
      check("second_done_rdy", 64'(req_rdy), 64'd1);

      // Reset pulsed in MEM_WAIT, then a late read response.
      req_vld = 1'b1; req_id = 1'b1; req_addr = 56'h80006000; mem_req_rdy = 1'b1;
      tick();
      req_vld = 1'b0;
      tick();
      check("rst_in_wait", 64'(mem_resp_rdy), 64'd1);
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      #2 rstn = 1'b1;
      mem_resp_vld = 1'b1; mem_resp_data = 64'hABCD; mem_resp_err = 1'b0;
      tick();
      mem_resp_vld = 1'b0;
      check("late_resp_vld", 64'(resp_vld), 64'd0);
      check("late_req_rdy", 64'(req_rdy), 64'd1);
      check("late_pte", resp_pte, 64'd0);
      tick();
      check("late_resp_vld2", 64'(resp_vld), 64'd0);

      run_random(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
